// File: rtl/ov7670_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_capture_if
// Purpose  : Frame-buffer write port (strobe, linear address, RGB444 data).
// Revision : 1.0 - initial release
// ============================================================================
interface ov7670_capture_if;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_capture
// Purpose  : OV7670 RGB444 byte-stream capture into a linear 640-wide frame
//            buffer. Define OV7670_TESTPAT_EN to replace pixel data with an
//            x/y test pattern while keeping camera framing.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  wire logic        pixel_clk,
    input  wire logic        rst_n,
    input  wire logic        capture_en,
    input  wire logic        cam_vsync,
    input  wire logic        cam_href,
    input  wire logic [7:0]  cam_data,
    ov7670_capture_if.master wr,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       frame_count,
    output logic             line_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    localparam logic [9:0] c_cnt_max  = 10'd1023;
    localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active = 10'(V_ACTIVE);

    state_t      r_state;
    logic        r_vs_d;
    logic        r_href_d;
    logic        r_phase;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_wr_en;
    logic [18:0] r_wr_addr;
    logic [11:0] r_wr_data;
    logic        r_frame_done;
    logic        r_busy;
    logic [7:0]  r_frame_count;
    logic        r_line_err;

    logic        w_sof;
    logic        w_eof;
    logic        w_in_range;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic [18:0] w_addr;
    logic [11:0] w_pix;

    assign w_sof      = r_vs_d & ~cam_vsync;
    assign w_eof      = ~r_vs_d & cam_vsync;
    assign w_in_range = (r_x < c_h_active) && (r_y < c_v_active);
    assign w_x_next   = (r_x == c_cnt_max) ? r_x : r_x + 10'd1;
    assign w_y_next   = (r_y == c_cnt_max) ? r_y : r_y + 10'd1;
    // y*640 + x as y*512 + y*128 + x
    assign w_addr     = {r_y, 9'd0} + {2'd0, r_y, 7'd0} + {9'd0, r_x};

`ifdef OV7670_TESTPAT_EN
    logic w_unused_data;
    assign w_unused_data = &{1'b0, cam_data};
    assign w_pix = {r_x[7:4], r_y[7:4], r_x[3:0] ^ r_y[3:0]};
`else
    logic [3:0] r_red;
    assign w_pix = {r_red, cam_data};
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_vs_d        <= 1'b0;
            r_href_d      <= 1'b0;
            r_phase       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
            r_line_err    <= 1'b0;
`ifndef OV7670_TESTPAT_EN
            r_red         <= '0;
`endif
        end else begin
            r_vs_d       <= cam_vsync;
            r_href_d     <= cam_href;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture_en) begin
                        r_state <= ST_WAIT_SOF;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (w_sof) begin
                        r_state    <= ST_ACTIVE;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_phase    <= 1'b0;
                        r_line_err <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // capture_en is only consulted here, so a running frame always completes
                    if (w_eof) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                        if (capture_en) begin
                            r_state <= ST_WAIT_SOF;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    if (cam_href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
`ifndef OV7670_TESTPAT_EN
                            r_red <= cam_data[3:0];
`endif
                        end else begin
                            if (w_in_range) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= w_addr;
                                r_wr_data <= w_pix;
                            end
                            r_x <= w_x_next;
                        end
                    end else if (r_href_d) begin
                        r_y     <= w_y_next;
                        r_x     <= '0;
                        r_phase <= 1'b0;
                        if (r_phase) begin
                            r_line_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr.wr_en    = r_wr_en;
    assign wr.wr_addr  = r_wr_addr;
    assign wr.wr_data  = r_wr_data;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;
    assign line_err    = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_capture
// Purpose  : Directed frame-level bench for ov7670_capture (reduced geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture;

    localparam int H = 24;
    localparam int V = 56;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       capture_en = 1'b0;
    logic       vs = 1'b1;
    logic       href = 1'b0;
    logic [7:0] data = 8'h00;
    logic       frame_done;
    logic       busy;
    logic [7:0] frame_count;
    logic       line_err;

    ov7670_capture_if fb ();

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .pixel_clk   (clk),
        .rst_n       (rst_n),
        .capture_en  (capture_en),
        .cam_vsync   (vs),
        .cam_href    (href),
        .cam_data    (data),
        .wr          (fb.master),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_count (frame_count),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [18:0] a;
        logic [11:0] d;
    } exp_t;
    exp_t exp_q[$];

    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          overlap = 0;
    logic [18:0] last_addr = '0;
    logic [18:0] max_addr = '0;
    logic [11:0] tp_val = '0;

    always @(negedge clk) begin
        if (fb.wr_en) begin
            exp_t e;
            wr_cnt++;
            last_addr = fb.wr_addr;
            if (fb.wr_addr > max_addr) max_addr = fb.wr_addr;
            if (fb.wr_addr == 19'(52 * 640 + 18)) tp_val = fb.wr_data;
            if (frame_done) overlap++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(fb.wr_addr), 32'(e.a));
                check_eq("wr_data", 32'(fb.wr_data), 32'(e.d));
            end
        end
        if (frame_done) fd_cnt++;
    end

    int g_rel = -1, g_drop = -1, g_arm = -1, g_odd = -1, g_lerr = -1;
    bit g_cap = 1'b0, g_pat = 1'b0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        href = 1'b1;
        data = b;
    endtask

    task automatic send_frame(input int nl, input int np);
        logic [7:0] b1, b2;
        logic [9:0] xx, yy;
        exp_t e;
        @(negedge clk);
        vs = 1'b1; href = 1'b0;
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
        for (int y = 0; y < nl; y++) begin
            if (y == g_rel) begin
                check_eq("rst_wr_en", 32'(fb.wr_en), 0);
                check_eq("rst_wr_addr", 32'(fb.wr_addr), 0);
                check_eq("rst_wr_data", 32'(fb.wr_data), 0);
                check_eq("rst_frame_done", 32'(frame_done), 0);
                check_eq("rst_busy", 32'(busy), 0);
                check_eq("rst_frame_count", 32'(frame_count), 0);
                check_eq("rst_line_err", 32'(line_err), 0);
                rst_n = 1'b1;
            end
            if (y == g_lerr) check_eq("line_err_clr_sof", 32'(line_err), 0);
            if (y == g_drop) capture_en = 1'b0;
            if (y == g_arm)  capture_en = 1'b1;
            for (int x = 0; x < np; x++) begin
                xx = 10'(x);
                yy = 10'(y);
                if (g_pat) begin
                    b1 = 8'(x * 3 + y) | 8'hA0;
                    b2 = 8'(x ^ (y << 2));
                end else begin
                    b1 = 8'h0A;
                    b2 = 8'h5C;
                end
                send_byte(b1);
                send_byte(b2);
                if (g_cap && x < H && y < V) begin
                    e.a = 19'(y * 640 + x);
`ifdef OV7670_TESTPAT_EN
                    e.d = {xx[7:4], yy[7:4], xx[3:0] ^ yy[3:0]};
`else
                    e.d = {b1[3:0], b2};
`endif
                    exp_q.push_back(e);
                end
            end
            if (y == g_odd) send_byte(8'hEE);
            @(negedge clk);
            href = 1'b0;
            repeat (3) @(negedge clk);
        end
        vs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_hooks();
        g_rel = -1; g_drop = -1; g_arm = -1; g_odd = -1; g_lerr = -1;
    endtask

    int w0, f0;

    initial begin
        // Reset held while the camera runs, released mid-frame with capture armed
        capture_en = 1'b1;
        clear_hooks();
        g_rel = 20; g_cap = 1'b0; g_pat = 1'b1;
        w0 = wr_cnt;
        send_frame(V, H);
        check_eq("rst_frame_writes", 32'(wr_cnt - w0), 0);
        check_eq("rst_busy_armed", 32'(busy), 1);
        check_eq("rst_count_after", 32'(frame_count), 0);

        // Nominal frame
        clear_hooks();
        g_cap = 1'b1; g_pat = 1'b0;
        w0 = wr_cnt; f0 = fd_cnt;
        send_frame(V, H);
        check_eq("nom_writes", 32'(wr_cnt - w0), 32'(H * V));
        check_eq("nom_last_addr", 32'(last_addr), 32'((V - 1) * 640 + H - 1));
        check_eq("nom_frame_done", 32'(fd_cnt - f0), 1);
        check_eq("nom_frame_count", 32'(frame_count), 1);
        check_eq("nom_line_err", 32'(line_err), 0);

        // Overlong lines and frame
        g_pat = 1'b1;
        max_addr = '0;
        w0 = wr_cnt;
        send_frame(V + 4, H + 6);
        check_eq("ovl_writes", 32'(wr_cnt - w0), 32'(H * V));
        check_eq("ovl_max_addr", 32'(max_addr), 32'((V - 1) * 640 + H - 1));
        check_eq("ovl_frame_count", 32'(frame_count), 2);

        // Odd byte count on line 3
        g_odd = 3;
        w0 = wr_cnt;
        send_frame(V, H);
        check_eq("odd_writes", 32'(wr_cnt - w0), 32'(H * V));
        check_eq("odd_line_err", 32'(line_err), 1);
        check_eq("odd_frame_count", 32'(frame_count), 3);

        // Enable dropped mid-frame; line_err must have cleared at SOF
        clear_hooks();
        g_drop = 10; g_lerr = 1;
        w0 = wr_cnt; f0 = fd_cnt;
        send_frame(V, H);
        check_eq("drop_writes", 32'(wr_cnt - w0), 32'(H * V));
        check_eq("drop_frame_done", 32'(fd_cnt - f0), 1);
        check_eq("drop_frame_count", 32'(frame_count), 4);
        check_eq("drop_busy", 32'(busy), 0);
        clear_hooks();
        g_cap = 1'b0;
        w0 = wr_cnt;
        send_frame(V, H);
        check_eq("idle_writes", 32'(wr_cnt - w0), 0);
        check_eq("idle_frame_count", 32'(frame_count), 4);

        // Late arm while vsync is low: nothing until the next SOF
        g_arm = 5;
        w0 = wr_cnt;
        send_frame(V, H);
        check_eq("late_writes", 32'(wr_cnt - w0), 0);
        check_eq("late_busy", 32'(busy), 1);
        check_eq("late_frame_count", 32'(frame_count), 4);
        clear_hooks();
        g_cap = 1'b1;
        w0 = wr_cnt;
        send_frame(V, H);
        check_eq("arm_writes", 32'(wr_cnt - w0), 32'(H * V));
        check_eq("arm_frame_count", 32'(frame_count), 5);
`ifdef OV7670_TESTPAT_EN
        check_eq("testpat_x12_y34", 32'(tp_val), 32'h136);
`endif

        // SOF immediately followed by EOF: empty frame
        w0 = wr_cnt; f0 = fd_cnt;
        vs = 1'b1;
        repeat (4) @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("empty_frame_done", 32'(fd_cnt - f0), 1);
        check_eq("empty_frame_count", 32'(frame_count), 6);
        check_eq("empty_writes", 32'(wr_cnt - w0), 0);

        check_eq("done_wr_overlap", 32'(overlap), 0);
        check_eq("exp_queue_left", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
